// File: rtl/ltl_monitor_collector.sv
// ltl_monitor_collector: reduces per-property report bits from the automata
// stage to hit flags, keeps sticky status and saturating hit counters, and
// logs every hit cycle as a timestamped event in a small FIFO.
//
// Ports:
//   clk_i, reset_ni       clock, asynchronous active-low reset
//   run_i                 sample enable (automata stage advances when high)
//   symbols_i             symbol consumed this cycle
//   report_bits_i         report bits, property p at [p*REPORTS_PER_PROP +: REPORTS_PER_PROP]
//   prop_enable_i         per-property enable
//   clear_i               synchronous clear of status, counters, FIFO and timestamp
//   prop_hit_o            registered one-cycle hit pulse per property
//   prop_sticky_o         sticky hit flag per property
//   hit_count_o           saturating hit counters, property p at [p*CNT_W +: CNT_W]
//   evt_valid_o/evt_ready_i  event drain handshake
//   evt_mask_o, evt_symbol_o, evt_ts_o  registered FIFO head entry
//   overflow_o            sticky: an event was dropped on a full FIFO
module ltl_monitor_collector #(
  parameter int unsigned NUM_PROPS        = 4,
  parameter int unsigned REPORTS_PER_PROP = 4,
  parameter int unsigned SYM_W            = 8,
  parameter int unsigned CNT_W            = 16,
  parameter int unsigned TS_W             = 32,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                                  clk_i,
  input  logic                                  reset_ni,
  input  logic                                  run_i,
  input  logic [SYM_W-1:0]                      symbols_i,
  input  logic [NUM_PROPS*REPORTS_PER_PROP-1:0] report_bits_i,
  input  logic [NUM_PROPS-1:0]                  prop_enable_i,
  input  logic                                  clear_i,
  output logic [NUM_PROPS-1:0]                  prop_hit_o,
  output logic [NUM_PROPS-1:0]                  prop_sticky_o,
  output logic [NUM_PROPS*CNT_W-1:0]            hit_count_o,
  output logic                                  evt_valid_o,
  input  logic                                  evt_ready_i,
  output logic [NUM_PROPS-1:0]                  evt_mask_o,
  output logic [SYM_W-1:0]                      evt_symbol_o,
  output logic [TS_W-1:0]                       evt_ts_o,
  output logic                                  overflow_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  // Registered state
  logic [NUM_PROPS-1:0] prop_hit_q, prop_sticky_q;
  logic [CNT_W-1:0]     cnt_q [NUM_PROPS];
  logic [CNT_W-1:0]     cnt_d [NUM_PROPS];
  logic [TS_W-1:0]      ts_q, ts_d;
  logic                 overflow_q;

  logic [NUM_PROPS-1:0] mem_mask_q [FIFO_DEPTH];
  logic [SYM_W-1:0]     mem_sym_q  [FIFO_DEPTH];
  logic [TS_W-1:0]      mem_ts_q   [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  logic                 head_valid_q;
  logic [NUM_PROPS-1:0] head_mask_q, head_mask_d;
  logic [SYM_W-1:0]     head_sym_q, head_sym_d;
  logic [TS_W-1:0]      head_ts_q, head_ts_d;

  logic [NUM_PROPS-1:0] hit_now_c;
  logic                 push_c, pop_c, full_c, push_ok_c, drop_c;

  // Per-property hit reduction, only in sample cycles
  always_comb begin
    hit_now_c = '0;
    for (int p = 0; p < int'(NUM_PROPS); p++) begin
      if (run_i && prop_enable_i[p]) begin
        hit_now_c[p] = |report_bits_i[p*REPORTS_PER_PROP +: REPORTS_PER_PROP];
      end
    end
  end

  // Saturating counter next values
  always_comb begin
    for (int p = 0; p < int'(NUM_PROPS); p++) begin
      cnt_d[p] = cnt_q[p];
      if (hit_now_c[p] && (cnt_q[p] != '1)) begin
        cnt_d[p] = cnt_q[p] + CNT_W'(1);
      end
    end
  end

  // FIFO control; a pop frees a slot for a same-cycle push when full
  always_comb begin
    push_c    = |hit_now_c;
    pop_c     = head_valid_q & evt_ready_i;
    full_c    = (count_q == CW'(FIFO_DEPTH));
    push_ok_c = push_c & (~full_c | pop_c);
    drop_c    = push_c & full_c & ~pop_c;
    wr_ptr_d  = wr_ptr_q + AW'(push_ok_c);
    rd_ptr_d  = rd_ptr_q + AW'(pop_c);
    count_d   = count_q + CW'(push_ok_c) - CW'(pop_c);
    ts_d      = run_i ? ts_q + TS_W'(1) : ts_q;
  end

  // Next head: the entry being written bypasses memory when it becomes the head
  always_comb begin
    head_mask_d = mem_mask_q[rd_ptr_d];
    head_sym_d  = mem_sym_q[rd_ptr_d];
    head_ts_d   = mem_ts_q[rd_ptr_d];
    if (push_ok_c && (wr_ptr_q == rd_ptr_d)) begin
      head_mask_d = hit_now_c;
      head_sym_d  = symbols_i;
      head_ts_d   = ts_q;
    end
  end

  // Event storage (contents need no reset; pointers qualify them)
  always_ff @(posedge clk_i) begin
    if (push_ok_c && !clear_i) begin
      mem_mask_q[wr_ptr_q] <= hit_now_c;
      mem_sym_q[wr_ptr_q]  <= symbols_i;
      mem_ts_q[wr_ptr_q]   <= ts_q;
    end
  end

  // Status, counters, timestamp and FIFO pointers; clear wins over everything
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      prop_hit_q    <= '0;
      prop_sticky_q <= '0;
      for (int p = 0; p < int'(NUM_PROPS); p++) cnt_q[p] <= '0;
      ts_q          <= '0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      head_valid_q  <= 1'b0;
      head_mask_q   <= '0;
      head_sym_q    <= '0;
      head_ts_q     <= '0;
    end else if (clear_i) begin
      prop_hit_q    <= '0;
      prop_sticky_q <= '0;
      for (int p = 0; p < int'(NUM_PROPS); p++) cnt_q[p] <= '0;
      ts_q          <= '0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      head_valid_q  <= 1'b0;
      head_mask_q   <= '0;
      head_sym_q    <= '0;
      head_ts_q     <= '0;
    end else begin
      prop_hit_q    <= hit_now_c;
      prop_sticky_q <= prop_sticky_q | hit_now_c;
      for (int p = 0; p < int'(NUM_PROPS); p++) cnt_q[p] <= cnt_d[p];
      ts_q          <= ts_d;
      overflow_q    <= overflow_q | drop_c;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      head_valid_q  <= (count_d != '0);
      head_mask_q   <= head_mask_d;
      head_sym_q    <= head_sym_d;
      head_ts_q     <= head_ts_d;
    end
  end

  // Output mapping
  for (genvar p = 0; p < int'(NUM_PROPS); p++) begin : g_cnt_out
    assign hit_count_o[p*CNT_W +: CNT_W] = cnt_q[p];
  end

  assign prop_hit_o    = prop_hit_q;
  assign prop_sticky_o = prop_sticky_q;
  assign evt_valid_o   = head_valid_q;
  assign evt_mask_o    = head_mask_q;
  assign evt_symbol_o  = head_sym_q;
  assign evt_ts_o      = head_ts_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_ltl_monitor_collector.sv
// Scoreboard bench for ltl_monitor_collector: stimulus pushes hand-computed
// expected events, a negedge monitor pops and compares on each handshake.
module tb_ltl_monitor_collector;

  localparam int unsigned NP = 4;
  localparam int unsigned RP = 4;
  localparam int unsigned SW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned TW = 32;
  localparam int unsigned FD = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              run;
  logic [SW-1:0]     symbols;
  logic [NP*RP-1:0]  report_bits;
  logic [NP-1:0]     prop_enable;
  logic              clear;
  logic [NP-1:0]     prop_hit;
  logic [NP-1:0]     prop_sticky;
  logic [NP*CW-1:0]  hit_count;
  logic              evt_valid;
  logic              evt_ready;
  logic [NP-1:0]     evt_mask;
  logic [SW-1:0]     evt_symbol;
  logic [TW-1:0]     evt_ts;
  logic              overflow;

  typedef struct packed {
    logic [NP-1:0] mask;
    logic [SW-1:0] sym;
    logic [TW-1:0] ts;
  } evt_t;

  evt_t          exp_q [$];
  int            checks = 0;
  int            errors = 0;
  logic [TW-1:0] exp_ts;
  logic [TW-1:0] ts0;

  always #5 clk = ~clk;

  ltl_monitor_collector #(
    .NUM_PROPS(NP), .REPORTS_PER_PROP(RP), .SYM_W(SW),
    .CNT_W(CW), .TS_W(TW), .FIFO_DEPTH(FD)
  ) dut (
    .clk_i(clk), .reset_ni(reset_n), .run_i(run), .symbols_i(symbols),
    .report_bits_i(report_bits), .prop_enable_i(prop_enable), .clear_i(clear),
    .prop_hit_o(prop_hit), .prop_sticky_o(prop_sticky), .hit_count_o(hit_count),
    .evt_valid_o(evt_valid), .evt_ready_i(evt_ready), .evt_mask_o(evt_mask),
    .evt_symbol_o(evt_symbol), .evt_ts_o(evt_ts), .overflow_o(overflow)
  );

  function automatic logic [CW-1:0] hc(input int p);
    return hit_count[p*CW +: CW];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; m is the hand-computed mask of an event that must be logged
  task automatic drive(input logic r, input logic [SW-1:0] s, input logic [NP*RP-1:0] b,
                       input logic [NP-1:0] en, input logic c, input logic rd,
                       input logic [NP-1:0] m);
    run = r; symbols = s; report_bits = b; prop_enable = en; clear = c; evt_ready = rd;
    if (m != '0) exp_q.push_back({m, s, exp_ts});
    if (c) exp_ts = '0;
    else if (r) exp_ts = exp_ts + TW'(1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic rd);
    drive(1'b1, '0, '0, 4'hF, 1'b0, rd, '0);
  endtask

  // Monitor: compare head against scoreboard on every accepted pop
  always @(negedge clk) begin
    if (reset_n && evt_valid && evt_ready) begin
      evt_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL evt_unexpected: got mask=%h sym=%h ts=%0d expected no event",
                 evt_mask, evt_symbol, evt_ts);
      end else begin
        e = exp_q.pop_front();
        if ({evt_mask, evt_symbol, evt_ts} !== e) begin
          errors++;
          $display("FAIL evt_entry: got mask=%h sym=%h ts=%0d expected mask=%h sym=%h ts=%0d",
                   evt_mask, evt_symbol, evt_ts, e.mask, e.sym, e.ts);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; run = 1'b1; symbols = '0; report_bits = '0; prop_enable = 4'hF;
    clear = 1'b0; evt_ready = 1'b1; exp_ts = '0; ts0 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_status", 64'({prop_hit, prop_sticky, evt_valid, overflow}), 64'(0));
    chk("rst_count", 64'(hit_count), 64'(0));
    chk("rst_head", 64'({evt_mask, evt_symbol, evt_ts}), 64'(0));
    reset_n = 1'b1;

    // Idle sample cycles 0..9
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      chk("idle", 64'({prop_hit, prop_sticky, evt_valid, overflow, hit_count}), 64'(0));
    end

    // Single hit: property 2 via bit 9 in sample cycle 10
    drive(1'b1, 8'h3C, 16'h0200, 4'hF, 1'b0, 1'b1, 4'b0100);
    chk("single_hit", 64'(prop_hit), 64'(4'b0100));
    chk("single_sticky", 64'(prop_sticky), 64'(4'b0100));
    chk("single_cnt2", 64'(hc(2)), 64'(1));
    chk("single_valid", 64'(evt_valid), 64'(1));
    idle(1'b1);
    chk("hit_pulse_end", 64'(prop_hit), 64'(0));
    chk("single_drained", 64'(evt_valid), 64'(0));

    // Multi-bit and multi-property: bits 0, 1, 12
    drive(1'b1, 8'hA5, 16'h1003, 4'hF, 1'b0, 1'b1, 4'b1001);
    chk("multi_hit", 64'(prop_hit), 64'(4'b1001));
    chk("multi_cnt0", 64'(hc(0)), 64'(1));
    chk("multi_cnt3", 64'(hc(3)), 64'(1));
    chk("multi_sticky", 64'(prop_sticky), 64'(4'b1101));
    idle(1'b1);
    idle(1'b1);

    // FIFO full: 6 hits with reader stalled, only first 4 retained
    ts0 = exp_ts;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, SW'(16 + i), 16'h0010, 4'hF, 1'b0, 1'b0, (i < 4) ? 4'b0010 : 4'b0000);
    end
    chk("full_overflow", 64'(overflow), 64'(1));
    chk("full_cnt1", 64'(hc(1)), 64'(6));
    chk("full_valid", 64'(evt_valid), 64'(1));
    idle(1'b0);
    chk("full_head_ts", 64'(evt_ts), 64'(ts0));
    chk("full_head_sym", 64'(evt_symbol), 64'(8'h10));
    // Full with a simultaneous pop: push accepted
    drive(1'b1, 8'h77, 16'h0010, 4'hF, 1'b0, 1'b1, 4'b0010);
    chk("fullpop_cnt1", 64'(hc(1)), 64'(7));
    chk("fullpop_overflow", 64'(overflow), 64'(1));
    for (int i = 0; i < 6; i++) idle(1'b1);
    chk("full_drained", 64'(evt_valid), 64'(0));
    chk("full_queue_empty", 64'(exp_q.size()), 64'(0));

    // Saturation: property 0 already at 1, 20 more hits, one push/pop per cycle
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, SW'(8'hC0 + i), 16'h0001, 4'hF, 1'b0, 1'b1, 4'b0001);
    end
    chk("sat_cnt0", 64'(hc(0)), 64'(15));
    idle(1'b1);
    idle(1'b1);
    chk("sat_drained", 64'(evt_valid), 64'(0));

    // Clear: pending entry on property 3, then clear with a hit on property 1
    drive(1'b1, 8'h01, 16'h8000, 4'hF, 1'b0, 1'b0, 4'b0000);
    drive(1'b1, 8'h02, 16'h0020, 4'hF, 1'b1, 1'b0, 4'b0000);
    chk("clr_hit", 64'(prop_hit), 64'(0));
    chk("clr_sticky", 64'(prop_sticky), 64'(0));
    chk("clr_count", 64'(hit_count), 64'(0));
    chk("clr_overflow", 64'(overflow), 64'(0));
    chk("clr_valid", 64'(evt_valid), 64'(0));

    // ts frozen while run=0, and no event for a hit with run=0
    idle(1'b1);
    idle(1'b1);
    drive(1'b0, 8'h55, 16'h0020, 4'hF, 1'b0, 1'b1, 4'b0000);
    chk("norun_hit", 64'(prop_hit), 64'(0));
    chk("norun_cnt1", 64'(hc(1)), 64'(0));
    drive(1'b0, 8'h00, 16'h0000, 4'hF, 1'b0, 1'b1, 4'b0000);
    chk("norun_valid", 64'(evt_valid), 64'(0));
    drive(1'b1, 8'h66, 16'h0020, 4'hF, 1'b0, 1'b1, 4'b0010);
    chk("postclr_cnt1", 64'(hc(1)), 64'(1));
    chk("postclr_sticky", 64'(prop_sticky), 64'(4'b0010));

    // Disabled property: ignored, but keeps sticky and counter
    drive(1'b1, 8'h99, 16'h0020, 4'b1101, 1'b0, 1'b1, 4'b0000);
    chk("dis_hit", 64'(prop_hit), 64'(0));
    chk("dis_cnt1", 64'(hc(1)), 64'(1));
    chk("dis_sticky", 64'(prop_sticky), 64'(4'b0010));
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("end_valid", 64'(evt_valid), 64'(0));
    chk("end_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ltl_monitor_collector.md
# ltl_monitor_collector

Parametrised report-collection stage for the runtime-verification monitors. It sits directly behind an automata stage and reduces per-property report-state bits to per-property hit flags. It also keeps sticky violation status and saturating hit counters per property. Every hit cycle is logged into a timestamped event FIFO with a valid/ready drain port for the core-side reader.

## Interface
- NUM_PROPS, 4, number of monitored properties (LTL formulas)
- REPORTS_PER_PROP, 4, report-state bits per property from the automata stage
- SYM_W, 8, width of the input symbol bus
- CNT_W, 16, width of each per-property hit counter
- TS_W, 32, width of the cycle timestamp
- FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  sample enable; the automata stage advances only when high
- symbols  in  SYM_W  symbol consumed by the automata stage this cycle
- report_bits  in  NUM_PROPS*REPORTS_PER_PROP  report bits; property p owns bits [p*REPORTS_PER_PROP +: REPORTS_PER_PROP]
- prop_enable  in  NUM_PROPS  per-property enable; disabled properties are ignored everywhere
- clear  in  1  synchronous clear of status, counters, FIFO and timestamp
- prop_hit  out  NUM_PROPS  registered per-property hit, one-cycle pulse
- prop_sticky  out  NUM_PROPS  sticky hit flag per property
- hit_count  out  NUM_PROPS*CNT_W  saturating hit counters, property p at [p*CNT_W +: CNT_W]
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  reader accepts the head
- evt_mask  out  NUM_PROPS  head entry: which properties hit
- evt_symbol  out  SYM_W  head entry: symbol in the hit cycle
- evt_ts  out  TS_W  head entry: timestamp of the hit cycle
- overflow  out  1  sticky flag: an event was dropped because the FIFO was full

## Operation
- Sample cycle: a cycle with run=1.
- hit_now[p] = prop_enable[p] & OR of property p's report bits, valid in a sample cycle only. Otherwise it is 0.
- Timestamp ts counts sample cycles. It increments after every sample cycle and wraps modulo 2^TS_W. The value logged for an event is ts before the increment.
- prop_hit register <= hit_now every cycle, including 0 when run=0.
- prop_sticky[p] is set by hit_now[p] and held until clear or reset.
- hit_count[p] increments by 1 per cycle with hit_now[p]=1, regardless of how many of its report bits are set. It saturates at 2^CNT_W-1 and never wraps.
- Event push: in any cycle with hit_now != 0, push {hit_now, symbols, ts}.
- Pop: occurs when evt_valid & evt_ready.
- Full with no pop: the push is dropped and overflow is set sticky. Counters and sticky flags still update.
- Full with a pop in the same cycle: the push is accepted and occupancy is unchanged.
- Empty with a push: evt_valid rises next cycle. The FIFO has no fall-through.
- run=0: no sampling and ts is frozen. The FIFO still drains.
- clear=1 takes priority over everything in the same cycle. All status, counters, ts, FIFO pointers and overflow go to 0. Any hit in that cycle is discarded, and prop_hit is 0 the next cycle.
- Disabling a property (prop_enable[p]=0) does not clear its sticky flag or counter.

## Timing
- Reset values: prop_hit=0, prop_sticky=0, hit_count=0, evt_valid=0, evt_mask=0, evt_symbol=0, evt_ts=0, overflow=0, ts=0. Reset clears the FIFO. It asserts asynchronously and deasserts on the clock.
- Latency from a hit in cycle t: prop_hit, prop_sticky, hit_count and overflow all update at edge t+1. evt_valid=1 in cycle t+1 if the FIFO was empty.
- evt_mask, evt_symbol and evt_ts are registered FIFO head outputs and are stable while evt_valid=1 and evt_ready=0.
- evt_valid must not drop without a pop, except on clear or reset.
- Reset mid-operation discards all FIFO contents with no drain.
- Throughput is one push and one pop per cycle.

## Test plan
- Reset then idle: reset low for 3 cycles, run=1, report_bits=0. Required: all outputs stay 0, ts=5 after 5 cycles.
- Single hit: property 2 report bit 9 set in sample cycle 10, symbols=0x3C. Required: prop_hit=4'b0100 for one cycle, prop_sticky[2]=1, hit_count[2]=1, and one event {mask=4'b0100, symbol=0x3C, ts=10}.
- Multi-bit and multi-property: bits 0, 1 and 12 set in one cycle. Required: hit_count[0]=1 (not 2), hit_count[3]=1, and one event with mask=4'b1001.
- FIFO full: evt_ready=0 with 6 consecutive hit cycles on depth 4. Required: 4 entries retained in order, overflow=1, hit_count=6. Then evt_ready=1 with a simultaneous hit on a full FIFO: the push is accepted, and draining returns ts values in order.
- Saturation: CNT_W=4 with 20 hit cycles. Required: hit_count=15.
- Clear: clear=1 in the same cycle as a hit on property 1. Required: next cycle all counters, sticky flags, overflow and evt_valid are 0, and prop_hit=0. A hit run=0 gets no event and ts is frozen.
